// File: rtl/bcd_counter_chain.sv
// N-digit BCD up/down counter with programmable terminal value.
// Each digit has its own increment/decrement cell. A ripple chain of
// "all lower digits are 9" / "all lower digits are 0" flags decides which
// digits step. No binary arithmetic is used on the count itself.

module bcd_digit (
   input  logic [3:0] d,
   input  logic       inc_en,
   input  logic       dec_en,
   output logic [3:0] d_inc,
   output logic [3:0] d_dec,
   output logic       carry_inc,
   output logic       carry_dec
);
   // One decade: next value and rollover flag for each direction.
   always_comb begin
      d_inc     = d;
      d_dec     = d;
      carry_inc = 1'b0;
      carry_dec = 1'b0;
      if (inc_en) begin
         if (d == 4'd9) begin
            d_inc     = 4'd0;
            carry_inc = 1'b1;
         end else begin
            d_inc = d + 4'd1;
         end
      end
      if (dec_en) begin
         if (d == 4'd0) begin
            d_dec     = 4'd9;
            carry_dec = 1'b1;
         end else begin
            d_dec = d - 4'd1;
         end
      end
   end
endmodule

module bcd_counter_chain #(
   parameter int DIGITS    = 4,
   parameter int MAX_VALUE = 9675,
   parameter int WRAP      = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_data,
   output logic [4*DIGITS-1:0]   count,
   output logic [DIGITS-1:0]     digit_carry,
   output logic                  tc,
   output logic                  load_err
);
   localparam int W = 4 * DIGITS;

   // Decimal-to-BCD conversion happens once, at elaboration.
   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] b;
      int           r;
      b = '0;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         b[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return b;
   endfunction

   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);
   localparam bit           WRAP_EN = (WRAP != 0);

   logic [DIGITS-1:0] all9;       // every digit below i is 9
   logic [DIGITS-1:0] all0;       // every digit below i is 0
   logic [DIGITS-1:0] nibble_ok;
   logic [DIGITS-1:0] carry_inc;
   logic [DIGITS-1:0] carry_dec;
   logic [W-1:0]      cnt_inc;
   logic [W-1:0]      cnt_dec;
   logic              load_ok;
   logic              at_max;
   logic              at_zero;

   assign all9[0] = 1'b1;
   assign all0[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      if (g < DIGITS - 1) begin : g_chain
         assign all9[g+1] = all9[g] & (count[4*g +: 4] == 4'd9);
         assign all0[g+1] = all0[g] & (count[4*g +: 4] == 4'd0);
      end
      assign nibble_ok[g] = (load_data[4*g +: 4] <= 4'd9);

      bcd_digit u_digit (
         .d         (count[4*g +: 4]),
         .inc_en    (all9[g]),
         .dec_en    (all0[g]),
         .d_inc     (cnt_inc[4*g +: 4]),
         .d_dec     (cnt_dec[4*g +: 4]),
         .carry_inc (carry_inc[g]),
         .carry_dec (carry_dec[g])
      );
   end

   // With every nibble <= 9, packed BCD orders the same as its decimal value,
   // so a plain unsigned compare against MAX_BCD is a decimal compare.
   assign load_ok = (&nibble_ok) && (load_data <= MAX_BCD);
   assign at_max  = (count == MAX_BCD);
   assign at_zero = (count == '0);

   // Count register and one-cycle pulses; priority is rst > load > en.
   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         digit_carry <= '0;
         tc          <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         digit_carry <= '0;
         tc          <= 1'b0;
         load_err    <= 1'b0;
         if (load) begin
            if (load_ok) count    <= load_data;
            else         load_err <= 1'b1;
         end else if (en) begin
            if (up) begin
               if (at_max) begin
                  tc <= 1'b1;
                  if (WRAP_EN) count <= '0;
               end else begin
                  count       <= cnt_inc;
                  digit_carry <= carry_inc;
               end
            end else begin
               if (at_zero) begin
                  tc <= 1'b1;
                  if (WRAP_EN) count <= MAX_BCD;
               end else begin
                  count       <= cnt_dec;
                  digit_carry <= carry_dec;
               end
            end
         end
      end
   end
endmodule
